// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver: pin synchroniser, 11-bit frame deserialiser with
// timeout, E0/F0 prefix folding, and a first-word-fall-through event FIFO.
module ps2_scan_fifo #(
  parameter int TIMEOUT_CYCLES = 6000,
  parameter int DEPTH          = 8,
  parameter int DROP_ON_ERR    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  input  logic                       rd_en,
  input  logic                       clr_stat,
  output logic [10:0]                rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_REL, S_EXT_REL} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev, fall;
  logic [10:0]   shreg, frame;
  logic [3:0]    bit_cnt;
  logic          frame_vld, frame_good, abort;
  logic [TW-1:0] timer;
  logic [7:0]    code;
  state_t        state_q, state_d;
  logic          push, bad;
  logic [10:0]   push_data;
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_d;
  logic          do_pop, do_wr, ovf_set;

  // Two-flop synchronisers; idle-high so reset never fakes a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall  = clk_prev & ~clk_sync[1];
  // Timer hits its limit on this cycle while a frame is partially received.
  assign abort = (bit_cnt != 4'd0) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));

  // Deserialiser: LSB-first shift, frame strobe on the 11th bit, idle timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      frame     <= '0;
      bit_cnt   <= '0;
      frame_vld <= 1'b0;
      timer     <= '0;
    end else begin
      frame_vld <= 1'b0;
      if (fall) begin
        timer <= '0;
        shreg <= {dat_sync[1], shreg[10:1]};
        if (bit_cnt == 4'd10) begin
          bit_cnt   <= '0;
          frame     <= {dat_sync[1], shreg[10:1]};
          frame_vld <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0 && timer != TW'(TIMEOUT_CYCLES)) begin
        timer <= timer + TW'(1);
        if (abort) bit_cnt <= '0;
      end
    end
  end

  // start=0, stop=1, odd parity across data+parity.
  assign frame_good = ~frame[0] & frame[10] & (^frame[9:1]);
  assign code       = frame[8:1];

  // Prefix state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Prefix folding: E0/F0 only move state; anything else emits one event.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_data = '0;
    bad       = 1'b0;
    if (frame_vld) begin
      if (!frame_good) begin
        bad     = 1'b1;
        state_d = S_IDLE;
        if (DROP_ON_ERR == 0) begin
          push      = 1'b1;
          push_data = {3'b100, code};
        end
      end else if (code == 8'hE0) begin
        case (state_q)
          S_IDLE:  state_d = S_EXT;
          S_REL:   state_d = S_EXT_REL;
          default: state_d = state_q;
        endcase
      end else if (code == 8'hF0) begin
        case (state_q)
          S_IDLE:  state_d = S_REL;
          S_EXT:   state_d = S_EXT_REL;
          default: state_d = state_q;
        endcase
      end else begin
        push      = 1'b1;
        push_data = {1'b0,
                     (state_q == S_EXT) || (state_q == S_EXT_REL),
                     (state_q == S_REL) || (state_q == S_EXT_REL),
                     code};
        state_d   = S_IDLE;
      end
    end
  end

  // A pop frees a slot in the same cycle, so a push while full still lands.
  assign do_pop  = rd_en & ~empty;
  assign do_wr   = push & (~full | do_pop);
  assign ovf_set = push & full & ~rd_en;
  assign rd_data = mem[rd_ptr];

  // Next occupancy, used for the registered full/empty flags.
  always_comb begin
    count_d = count + CW'(do_wr) - CW'(do_pop);
  end

  // FIFO storage, pointers and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      empty <= (count_d == '0);
      full  <= (count_d == CW'(DEPTH));
    end
  end

  // Sticky statistics; clear takes priority over a same-cycle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else if (clr_stat) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if ((bad | abort) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (ovf_set) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Bench for ps2_scan_fifo: one instance drops bad frames, one queues them.
module tb_ps2_scan_fifo;
  localparam int TMO = 100;
  localparam int DEP = 8;
  localparam int H   = 8;   // PS/2 half period in clk cycles

  logic clk = 1'b0, rst = 1'b1;
  logic ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0, clr_stat = 1'b0;
  logic [10:0] rd_data_d, rd_data_k;
  logic empty_d, empty_k, full_d, full_k, ovf_d, ovf_k;
  logic [3:0] count_d, count_k;
  logic [7:0] err_d, err_k;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  ps2_scan_fifo #(.TIMEOUT_CYCLES(TMO), .DEPTH(DEP), .DROP_ON_ERR(1)) u_drop (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .clr_stat(clr_stat), .rd_data(rd_data_d), .empty(empty_d), .full(full_d),
    .count(count_d), .overflow(ovf_d), .err_cnt(err_d));

  ps2_scan_fifo #(.TIMEOUT_CYCLES(TMO), .DEPTH(DEP), .DROP_ON_ERR(0)) u_keep (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .clr_stat(clr_stat), .rd_data(rd_data_k), .empty(empty_k), .full(full_k),
    .count(count_k), .overflow(ovf_k), .err_cnt(err_k));

  // Reference model: key events as queues, prefixes as two flags.
  logic [10:0] q_d[$], q_k[$];
  bit m_ext, m_rel, m_ovf_d, m_ovf_k;
  int m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    q_d.delete(); q_k.delete();
    m_ext = 0; m_rel = 0; m_ovf_d = 0; m_ovf_k = 0; m_err = 0;
  endtask

  task automatic m_pop();
    if (q_d.size() > 0) void'(q_d.pop_front());
    if (q_k.size() > 0) void'(q_k.pop_front());
  endtask

  task automatic m_push(input bit keep_only, input logic [10:0] e);
    if (!keep_only) begin
      if (q_d.size() == DEP) m_ovf_d = 1; else q_d.push_back(e);
    end
    if (q_k.size() == DEP) m_ovf_k = 1; else q_k.push_back(e);
  endtask

  task automatic m_frame(input logic [7:0] code, input bit bad, input bit pop_first);
    if (pop_first) m_pop();
    if (bad) begin
      if (m_err < 255) m_err++;
      m_ext = 0; m_rel = 0;
      m_push(1, {3'b100, code});
    end else if (code == 8'hE0) m_ext = 1;
    else if (code == 8'hF0) m_rel = 1;
    else begin
      m_push(0, {1'b0, m_ext, m_rel, code});
      m_ext = 0; m_rel = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cnt_d"}, count_d, q_d.size());
    chk({tag, "_cnt_k"}, count_k, q_k.size());
    if (q_d.size() > 0) chk({tag, "_head_d"}, rd_data_d, q_d[0]);
    if (q_k.size() > 0) chk({tag, "_head_k"}, rd_data_k, q_k[0]);
    chk({tag, "_err_d"}, err_d, m_err);
    chk({tag, "_err_k"}, err_k, m_err);
    chk({tag, "_ovf_d"}, ovf_d, m_ovf_d);
    chk({tag, "_ovf_k"}, ovf_k, m_ovf_k);
  endtask

  // mode 0 plain, 1 checks push latency, 2 pulses rd_en on the push cycle.
  task automatic send_frame(input logic [7:0] code, input bit bad, input int nbits, input int mode);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (3) @(posedge clk);
        #1 chk("lat_empty_n2", empty_d, 1);
        @(posedge clk);
        #1 chk("lat_empty_n3", empty_d, 0);
        chk("lat_count_n3", count_d, 1);
      end
      if (i == 10 && mode == 2) begin
        repeat (3) @(posedge clk);
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
      end
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (nbits == 11) m_frame(code, bad, mode == 2);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    m_pop();
  endtask

  task automatic clr();
    @(negedge clk); clr_stat = 1'b1;
    @(negedge clk); clr_stat = 1'b0;
    m_err = 0; m_ovf_d = 0; m_ovf_k = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, count_d, 0);
    chk({tag, "_empty"}, empty_d, 1);
    chk({tag, "_full"}, full_d, 0);
    chk({tag, "_ovf"}, ovf_d, 0);
    chk({tag, "_err"}, err_d, 0);
    chk({tag, "_rdata"}, rd_data_d, 0);
    chk({tag, "_rdata_k"}, rd_data_k, 0);
  endtask

  typedef struct {
    logic [7:0]  code;
    bit          bad;
    bit          p_d;
    logic [10:0] e_d;
    bit          p_k;
    logic [10:0] e_k;
  } vec_t;

  vec_t tbl[17];
  logic [10:0] exp3[8];
  logic [7:0]  fill[9];

  initial begin
    tbl[0]  = '{8'hE0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[1]  = '{8'h74, 1'b0, 1'b1, 11'h274, 1'b1, 11'h274};
    tbl[2]  = '{8'hE0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[3]  = '{8'hF0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[4]  = '{8'h74, 1'b0, 1'b1, 11'h374, 1'b1, 11'h374};
    tbl[5]  = '{8'h1C, 1'b1, 1'b0, 11'h000, 1'b1, 11'h41C};
    tbl[6]  = '{8'h32, 1'b0, 1'b1, 11'h032, 1'b1, 11'h032};
    tbl[7]  = '{8'hE0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[8]  = '{8'hE0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[9]  = '{8'h75, 1'b0, 1'b1, 11'h275, 1'b1, 11'h275};
    tbl[10] = '{8'hF0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[11] = '{8'hF0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[12] = '{8'h12, 1'b0, 1'b1, 11'h112, 1'b1, 11'h112};
    tbl[13] = '{8'hF0, 1'b0, 1'b0, 11'h000, 1'b0, 11'h000};
    tbl[14] = '{8'h1C, 1'b1, 1'b0, 11'h000, 1'b1, 11'h41C};
    tbl[15] = '{8'h1C, 1'b0, 1'b1, 11'h01C, 1'b1, 11'h01C};
    tbl[16] = '{8'hE1, 1'b0, 1'b1, 11'h0E1, 1'b1, 11'h0E1};
    fill = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    exp3 = '{11'h01E, 11'h026, 11'h025, 11'h02E, 11'h036, 11'h03D, 11'h03E, 11'h045};
    m_reset();

    repeat (3) @(negedge clk);
    chk_reset("rst_held");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst_rel");

    // make then break of the same key
    send_frame(8'h1C, 0, 11, 1);
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h1C, 0, 11, 0);
    chk("t1_count", count_d, 2);
    chk("t1_head0", rd_data_d, 11'h01C);
    pop();
    chk("t1_head1", rd_data_d, 11'h11C);
    pop();
    chk("t1_empty", empty_d, 1);

    // prefix and error vectors, drained one at a time
    for (int i = 0; i < 17; i++) begin
      send_frame(tbl[i].code, tbl[i].bad, 11, 0);
      chk($sformatf("tbl%0d_cnt_d", i), count_d, tbl[i].p_d);
      chk($sformatf("tbl%0d_cnt_k", i), count_k, tbl[i].p_k);
      if (tbl[i].p_d) chk($sformatf("tbl%0d_data_d", i), rd_data_d, tbl[i].e_d);
      if (tbl[i].p_k) chk($sformatf("tbl%0d_data_k", i), rd_data_k, tbl[i].e_k);
      pop();
    end
    chk("tbl_err_d", err_d, 2);
    chk("tbl_err_k", err_k, 2);

    // fill past capacity, then push and pop together while full
    for (int i = 0; i < 9; i++) send_frame(fill[i], 0, 11, 0);
    chk("t3_full", full_d, 1);
    chk("t3_count", count_d, 8);
    chk("t3_ovf", ovf_d, 1);
    chk("t3_head", rd_data_d, 11'h016);
    clr();
    send_frame(8'h45, 0, 11, 2);
    chk("t3_count_rw", count_d, 8);
    chk("t3_ovf_rw", ovf_d, 0);
    chk("t3_full_rw", full_d, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_drain%0d", i), rd_data_k, exp3[i]);
      pop();
    end
    chk("t3_empty", empty_d, 1);

    // timeout keeps the release prefix
    clr();
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h1C, 0, 6, 0);
    repeat (TMO + 10) @(negedge clk);
    m_err++;
    chk("t5_err", err_d, 1);
    chk("t5_empty", empty_d, 1);
    send_frame(8'h1C, 0, 11, 0);
    chk("t5_data", rd_data_d, 11'h11C);
    pop();
    clr();
    chk("t5_clr_err", err_d, 0);
    chk("t5_clr_ovf", ovf_d, 0);

    // reset in the middle of a frame; leave old data in storage first
    send_frame(8'h33, 0, 11, 0);
    send_frame(8'h1C, 0, 4, 0);
    @(negedge clk); ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("t6_rst");
    rst = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    send_frame(8'h2D, 0, 11, 0);
    chk("t6_count", count_d, 1);
    chk("t6_data", rd_data_d, 11'h02D);
    chk("t6_err", err_d, 0);
    chk("t6_ovf", ovf_d, 0);
    pop();

    // random frames against the reference model
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [7:0] c;
      bit b;
      r = $urandom_range(0, 9);
      c = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0);
      send_frame(c, b, 11, 0);
      check_model($sformatf("rnd%0d", i));
      if ($urandom_range(0, 9) < 5) pop();
    end
    check_model("rnd_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
